// File: rtl/prbs_link_sequencer.sv
// prbs_link_sequencer: drives the TX byte stream for link bring-up.
// It sends the alignment word a programmed number of times, waits (with a
// timeout) for the receive-side detector to report lock, then streams a
// programmed number of PRBS bytes. Busy/done/locked/error go to the host.
module prbs_link_sequencer #(
  parameter logic [31:0] PATTERN = 32'hAABBCCDD,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        start,
  input  logic [7:0]  n,
  input  logic [15:0] prbs_len,
  input  logic [7:0]  prbs_byte,
  input  logic        pattern_detected,
  output logic        prbs_en,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  output logic        busy,
  output logic        done,
  output logic        locked,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_PAT  = 3'd1,
    WAIT_LOCK = 3'd2,
    SEND_PRBS = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Last timer value before WAIT_LOCK gives up (timer starts at 0).
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  n_q;        // repetitions latched at start accept
  logic [15:0] len_q;      // PRBS length latched at start accept
  logic [1:0]  idx_q;      // byte index within the alignment word
  logic [7:0]  rep_q;      // completed repetitions of the word
  logic [15:0] timer_q;    // cycles spent in WAIT_LOCK
  logic [15:0] pcnt_q;     // PRBS bytes sent
  logic        locked_q;
  logic        error_q;

  logic        pat_last;
  logic        lock_seen;
  logic        tmo_hit;
  logic        prbs_last;
  logic        in_run;
  logic [7:0]  pat_byte;

  // Terminal-count and status decodes shared by the FSM.
  assign pat_last  = (idx_q == 2'd3) && (rep_q == (n_q - 8'd1));
  assign lock_seen = locked_q | pattern_detected;
  assign tmo_hit   = (timer_q == TMO_LAST);
  assign prbs_last = (pcnt_q == (len_q - 16'd1));
  // Detection only counts while the run is still in progress, not in DONE.
  assign in_run    = (state_q == SEND_PAT) || (state_q == WAIT_LOCK) ||
                     (state_q == SEND_PRBS);

  // Alignment word byte select, MSB byte first.
  always_comb begin
    pat_byte = PATTERN[31:24];
    case (idx_q)
      2'd0:    pat_byte = PATTERN[31:24];
      2'd1:    pat_byte = PATTERN[23:16];
      2'd2:    pat_byte = PATTERN[15:8];
      default: pat_byte = PATTERN[7:0];
    endcase
  end

  // Sequencer FSM with its counters and sticky status bits.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      n_q      <= 8'd0;
      len_q    <= 16'd0;
      idx_q    <= 2'd0;
      rep_q    <= 8'd0;
      timer_q  <= 16'd0;
      pcnt_q   <= 16'd0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      if (in_run && pattern_detected)
        locked_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            n_q      <= n;
            len_q    <= prbs_len;
            idx_q    <= 2'd0;
            rep_q    <= 8'd0;
            timer_q  <= 16'd0;
            pcnt_q   <= 16'd0;
            locked_q <= 1'b0;
            if (n == 8'd0) begin
              error_q <= 1'b1;
              state_q <= DONE;
            end else begin
              error_q <= 1'b0;
              state_q <= SEND_PAT;
            end
          end
        end

        SEND_PAT: begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3)
            rep_q <= rep_q + 8'd1;
          if (pat_last)
            state_q <= WAIT_LOCK;
        end

        WAIT_LOCK: begin
          timer_q <= timer_q + 16'd1;
          if (lock_seen) begin
            state_q <= (len_q == 16'd0) ? DONE : SEND_PRBS;
          end else if (tmo_hit) begin
            error_q <= 1'b1;
            state_q <= DONE;
          end
        end

        SEND_PRBS: begin
          pcnt_q <= pcnt_q + 16'd1;
          if (prbs_last)
            state_q <= DONE;
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Moore output decodes; PRBS bytes pass straight through while streaming.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign prbs_en   = (state_q == SEND_PRBS);
  assign out_valid = (state_q == SEND_PAT) || (state_q == SEND_PRBS);
  assign out_byte  = (state_q == SEND_PAT)  ? pat_byte  :
                     (state_q == SEND_PRBS) ? prbs_byte : 8'h00;
  assign locked    = locked_q;
  assign error     = error_q;

endmodule

// File: tb/tb_prbs_link_sequencer.sv
// Directed bench for prbs_link_sequencer with a byte scoreboard.
module tb_prbs_link_sequencer;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  n = 8'd0;
  logic [15:0] prbs_len = 16'd0;
  logic [7:0]  prbs_byte = 8'h5A;
  logic        pattern_detected = 1'b0;
  logic        prbs_en, out_valid, busy, done, locked, error;
  logic [7:0]  out_byte;

  prbs_link_sequencer #(.PATTERN(32'hAABBCCDD), .TIMEOUT(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .n(n), .prbs_len(prbs_len),
    .prbs_byte(prbs_byte), .pattern_detected(pattern_detected),
    .prbs_en(prbs_en), .out_byte(out_byte), .out_valid(out_valid),
    .busy(busy), .done(done), .locked(locked), .error(error)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [7:0] b; logic p; } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int ta = 0;
  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int prbs_cnt = 0;
  int done_p = 0;
  bit done_seen = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Stand-in PRBS generator: steps by a constant whenever advanced.
  always @(posedge CLK) if (prbs_en) prbs_byte <= prbs_byte + 8'h13;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input int j);
    case (j)
      0: return 8'hAA;
      1: return 8'hBB;
      2: return 8'hCC;
      default: return 8'hDD;
    endcase
  endfunction

  // Output monitor: pops the scoreboard on every valid byte.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (done) begin
        done_seen = 1'b1;
        done_p = cyc - ta + 1;
        chk("done_busy", 32'(busy), 32'd1);
      end
      if (out_valid) begin
        exp_t e;
        valid_cnt++;
        if (prbs_en) prbs_cnt++;
        if (sb.size() == 0) begin
          chk("sb_extra", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_byte", 32'(out_byte), 32'(e.b));
          chk("prbs_en", 32'(prbs_en), 32'(e.p));
        end
      end else begin
        chk("idle_byte", 32'(out_byte), 32'd0);
        chk("idle_prbs_en", 32'(prbs_en), 32'd0);
      end
    end
  end

  task automatic start_run(input logic [7:0] nn, input logic [15:0] len, input bit exp_lock);
    logic [7:0] v;
    @(negedge CLK);
    for (int r = 0; r < int'(nn); r++)
      for (int j = 0; j < 4; j++) sb.push_back('{pbyte(j), 1'b0});
    if (exp_lock) begin
      v = prbs_byte;
      for (int k = 0; k < int'(len); k++) begin
        sb.push_back('{v, 1'b1});
        v = v + 8'h13;
      end
    end
    done_seen = 1'b0;
    valid_cnt = 0;
    prbs_cnt = 0;
    n = nn;
    prbs_len = len;
    start = 1'b1;
    @(posedge CLK);
    #1;
    ta = cyc;
    start = 1'b0;
    n = ~nn;
    prbs_len = ~len;
  endtask

  // Per-period stimulus: detect pulse at period det, stray start at period rs.
  task automatic drive_events(input int det, input int rs, input int upto);
    for (int p = 1; p <= upto; p++) begin
      pattern_detected = (p == det);
      start = (p == rs);
      if (p == rs) n = 8'd7;
      @(posedge CLK);
      #1;
    end
    pattern_detected = 1'b0;
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int exp_done, input bit exp_lock,
                            input bit exp_err, input int exp_valid, input int exp_prbs);
    int k = 0;
    while (!done_seen && k < exp_done + 32) begin
      @(posedge CLK);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_p), 32'(exp_done));
    #1;
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_after"}, 32'(done), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'(exp_lock));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_valid_cnt"}, 32'(valid_cnt), 32'(exp_valid));
    chk({tag, "_prbs_cnt"}, 32'(prbs_cnt), 32'(exp_prbs));
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_prbs_en", 32'(prbs_en), 32'd0);
    chk("rst_byte", 32'(out_byte), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) @(posedge CLK);

    // Normal run: n=2, prbs_len=3, detect at period 8
    start_run(8'd2, 16'd3, 1'b1);
    drive_events(8, 0, 8);
    finish_run("normal", 13, 1'b1, 1'b0, 11, 3);

    // Timeout: no detect, WAIT_LOCK runs 16 cycles
    start_run(8'd1, 16'd4, 1'b0);
    finish_run("timeout", 21, 1'b0, 1'b1, 4, 0);

    // Zero repetitions
    start_run(8'd0, 16'd5, 1'b0);
    finish_run("n_zero", 1, 1'b0, 1'b1, 0, 0);

    // Zero PRBS length, detect during SEND_PAT
    start_run(8'd1, 16'd0, 1'b1);
    drive_events(3, 0, 3);
    finish_run("len_zero", 6, 1'b1, 1'b0, 4, 0);

    // Stray start during SEND_PAT is ignored
    start_run(8'd2, 16'd2, 1'b1);
    drive_events(6, 3, 6);
    finish_run("restart", 12, 1'b1, 1'b0, 10, 2);

    // Reset asserted during SEND_PRBS
    start_run(8'd1, 16'd8, 1'b1);
    drive_events(3, 0, 3);
    repeat (3) @(posedge CLK);
    #3;
    RSTn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_prbs_en", 32'(prbs_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_byte", 32'(out_byte), 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    sb.delete();
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("mid_rst_no_done", 32'(done_seen), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);

    // Normal run after reset
    start_run(8'd1, 16'd2, 1'b1);
    drive_events(4, 0, 4);
    finish_run("post_rst", 8, 1'b1, 1'b0, 6, 2);

    // Max repetitions, early lock
    start_run(8'd255, 16'd2, 1'b1);
    drive_events(5, 0, 5);
    finish_run("max_rep", 1024, 1'b1, 1'b0, 1022, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
